// File: rtl/uart_tx_pkg.sv
// Shared serial-subsystem definitions: data word type, transmitter states and
// the default baud divide used by both the transmit and receive counters.
package Definitions_Package;

   localparam int WORD_LENGTH  = 8;
   localparam int DEFAULT_BAUD = 434;

   typedef logic [WORD_LENGTH-1:0] word_lenght_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic parity_of(input word_lenght_t data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last count so the transmitter can advance one bit.
module cntr_baud_tx_ovf
   import Definitions_Package::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_BAUD
) (
   input  logic clk,
   input  logic rst,
   input  logic enb,
   input  logic clear,
   output logic ovf
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enb) begin
         count <= (count == LAST) ? '0 : count + CNT_W'(1);
      end
   end

   assign ovf = enb && !clear && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches a byte on request and shifts out start, data (LSB
// first), optional parity and one or two stop bits, each one baud period long.
module uart_tx
   import Definitions_Package::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_BAUD,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tx_start,
   input  word_lenght_t tx_data,
   output logic         tx,
   output logic         busy,
   output logic         done
);

   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   uart_tx_state_t state;
   word_lenght_t   shift;
   logic [2:0]     bit_cnt;
   logic           parity_bit;
   logic           baud_ovf;

   cntr_baud_tx_ovf #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .enb  (state != IDLE),
      .clear(state == IDLE),
      .ovf  (baud_ovf)
   );

   // tx is loaded with the level of the bit being entered, so it changes on the
   // same edge as the state and never depends combinationally on an input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shift      <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_start) begin
                  shift      <= tx_data;
                  parity_bit <= parity_of(tx_data, PARITY_ODD);
                  bit_cnt    <= '0;
                  state      <= START;
                  tx         <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            START: begin
               if (baud_ovf) begin
                  state <= DATA;
                  tx    <= shift[0];
               end
            end
            DATA: begin
               if (baud_ovf) begin
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (PARITY_EN) begin
                        state <= PARITY;
                        tx    <= parity_bit;
                     end else begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     tx <= shift[1];
                  end
               end
            end
            PARITY: begin
               if (baud_ovf) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
            end
            STOP: begin
               // bit_cnt wrapped to 0 leaving DATA, so it counts stop periods here
               if (baud_ovf) begin
                  if (bit_cnt == LAST_STOP) begin
                     state   <= IDLE;
                     bit_cnt <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations checked every cycle
// against a frame-level model, plus directed literal expectations.
module tb_uart_tx;
   import Definitions_Package::*;

   localparam int NDUT = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   start_vec;
   word_lenght_t tx_data;
   logic [3:0]   tx_vec, busy_vec, done_vec;

   int checks = 0;
   int errors = 0;
   int cur    = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(434), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst(rst), .tx_start(start_vec[0]), .tx_data(tx_data),
      .tx(tx_vec[0]), .busy(busy_vec[0]), .done(done_vec[0]));
   uart_tx #(.CLKS_PER_BIT(434), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .rst(rst), .tx_start(start_vec[1]), .tx_data(tx_data),
      .tx(tx_vec[1]), .busy(busy_vec[1]), .done(done_vec[1]));
   uart_tx #(.CLKS_PER_BIT(434), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
      .clk(clk), .rst(rst), .tx_start(start_vec[2]), .tx_data(tx_data),
      .tx(tx_vec[2]), .busy(busy_vec[2]), .done(done_vec[2]));
   uart_tx #(.CLKS_PER_BIT(5), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) u_dut3 (
      .clk(clk), .rst(rst), .tx_start(start_vec[3]), .tx_data(tx_data),
      .tx(tx_vec[3]), .busy(busy_vec[3]), .done(done_vec[3]));

   function automatic int cfgN(input int d);
      return (d == 3) ? 5 : 434;
   endfunction
   function automatic bit cfgParity(input int d);
      return d != 0;
   endfunction
   function automatic bit cfgOdd(input int d);
      return (d == 2) || (d == 3);
   endfunction
   function automatic int cfgStop(input int d);
      return (d == 3) ? 2 : 1;
   endfunction

   // Model: a frame is a list of line levels; t counts cycles since acceptance
   // (0 = idle, 1..F inside the frame, F+1 = the done cycle).
   int          t[NDUT]      = '{default: 0};
   logic [11:0] fbits[NDUT]  = '{default: '1};
   int          fbitsN[NDUT] = '{default: 0};
   int          mf;
   logic [2:0]  mexp, mact;

   function automatic void buildFrame(input int d, input word_lenght_t data);
      int n;
      n = 0;
      fbits[d] = '1;
      fbits[d][n] = 1'b0;
      n++;
      for (int i = 0; i < 8; i++) begin
         fbits[d][n] = data[i];
         n++;
      end
      if (cfgParity(d)) begin
         fbits[d][n] = (($countones(data) % 2) == 1) ^ cfgOdd(d);
         n++;
      end
      n += cfgStop(d);
      fbitsN[d] = n;
   endfunction

   always @(posedge clk or negedge clk) begin
      if (clk) begin
         for (int d = 0; d < NDUT; d++) begin
            mf = fbitsN[d] * cfgN(d);
            if (!rst) t[d] = 0;
            else if (t[d] >= 1 && t[d] <= mf) t[d] = t[d] + 1;
            else if (start_vec[d]) begin
               buildFrame(d, tx_data);
               t[d] = 1;
            end else t[d] = 0;
         end
      end else begin
         for (int d = 0; d < NDUT; d++) begin
            if (!rst) t[d] = 0;
            mf = fbitsN[d] * cfgN(d);
            if (t[d] == 0) mexp = 3'b100;
            else if (t[d] <= mf) mexp = {fbits[d][(t[d] - 1) / cfgN(d)], 2'b10};
            else mexp = 3'b101;
            mact = {tx_vec[d], busy_vec[d], done_vec[d]};
            checks++;
            if (mact !== mexp) begin
               errors++;
               $display("[TB] FAIL model_dut%0d t=%0d: {tx,busy,done} got %b expected %b",
                        d, t[d], mact, mexp);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkWord(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic stepTo(input int c);
      while (cur < c) begin
         @(posedge clk);
         @(negedge clk);
         cur++;
      end
   endtask

   // Called at a falling edge; returns at the falling edge of frame cycle 1.
   task automatic applyStimulus(input logic [3:0] mask, input word_lenght_t data);
      tx_data   = data;
      start_vec = mask;
      @(posedge clk);
      @(negedge clk);
      start_vec = '0;
      cur = 1;
   endtask

   // Samples the middle of each bit period, optionally pulsing a request mid-frame.
   task automatic receiveFrame(input int d, input int n, input int nb, input int inject_at,
                               output logic [11:0] line);
      int sc;
      line = '0;
      for (int k = 0; k < nb; k++) begin
         sc = 1 + k * n + n / 2;
         if (inject_at > 0 && cur < inject_at && sc >= inject_at) begin
            stepTo(inject_at);
            tx_data      = 8'hFF;
            start_vec[d] = 1'b1;
            stepTo(inject_at + 1);
            start_vec[d] = 1'b0;
         end
         stepTo(sc);
         line[k] = tx_vec[d];
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [11:0] line;
      rst       = 1'b0;
      start_vec = '0;
      tx_data   = '0;
      repeat (50) @(negedge clk);
      checkWord("reset_tx", {8'h0, tx_vec}, 12'h00F);
      checkWord("reset_busy", {8'h0, busy_vec}, 12'h000);
      #2 rst = 1'b1;
      @(negedge clk);
      checkWord("release_done", {8'h0, done_vec}, 12'h000);
      cur = 0;
      stepTo(2000);
      checkWord("idle_tx", {8'h0, tx_vec}, 12'h00F);
      checkWord("idle_busy", {8'h0, busy_vec}, 12'h000);

      // 0x55 on 8N1
      applyStimulus(4'b0001, 8'h55);
      checkOutput("x55_busy_cycle1", busy_vec[0], 1'b1);
      receiveFrame(0, 434, 10, 0, line);
      checkWord("x55_line", line, 12'b0010_1010_1010);
      stepTo(4340);
      checkOutput("x55_done_early", done_vec[0], 1'b0);
      stepTo(4341);
      checkOutput("x55_done", done_vec[0], 1'b1);
      checkOutput("x55_busy_end", busy_vec[0], 1'b0);

      // loopback receive of 0xA3
      stepTo(cur + 5);
      applyStimulus(4'b0001, 8'hA3);
      receiveFrame(0, 434, 10, 0, line);
      checkWord("loop_data", {4'h0, line[8:1]}, 12'h0A3);
      checkOutput("loop_start", line[0], 1'b0);
      checkOutput("loop_stop", line[9], 1'b1);
      stepTo(4341);
      checkOutput("loop_done", done_vec[0], 1'b1);

      // parity, even on dut1 and odd on dut2
      stepTo(cur + 5);
      applyStimulus(4'b0110, 8'h07);
      stepTo(1 + 434 + 217);
      checkOutput("par_d0_even", tx_vec[1], 1'b1);
      stepTo(1 + 9 * 434 + 217);
      checkOutput("par_even_bit", tx_vec[1], 1'b1);
      checkOutput("par_odd_bit", tx_vec[2], 1'b0);
      stepTo(11 * 434);
      checkWord("par_busy_last", {10'h0, busy_vec[2:1]}, 12'h003);
      stepTo(11 * 434 + 1);
      checkWord("par_done", {10'h0, done_vec[2:1]}, 12'h003);

      // busy ignore and back-to-back
      stepTo(cur + 5);
      applyStimulus(4'b0001, 8'h12);
      receiveFrame(0, 434, 10, 2000, line);
      checkWord("busy_ignore_data", {4'h0, line[8:1]}, 12'h012);
      stepTo(4341);
      checkOutput("b2b_done", done_vec[0], 1'b1);
      checkOutput("b2b_gap_tx", tx_vec[0], 1'b1);
      applyStimulus(4'b0001, 8'h34);
      checkOutput("b2b_start_tx", tx_vec[0], 1'b0);
      checkOutput("b2b_start_busy", busy_vec[0], 1'b1);
      receiveFrame(0, 434, 10, 0, line);
      checkWord("b2b_data", {4'h0, line[8:1]}, 12'h034);
      stepTo(4341);

      // two stop bits with odd parity, short baud
      stepTo(cur + 5);
      applyStimulus(4'b1000, 8'h00);
      receiveFrame(3, 5, 12, 0, line);
      checkWord("stop2_line", line, 12'b1110_0000_0000);
      stepTo(60);
      checkOutput("stop2_busy_last", busy_vec[3], 1'b1);
      stepTo(61);
      checkOutput("stop2_done", done_vec[3], 1'b1);

      // reset in the middle of data bit 3
      stepTo(cur + 5);
      applyStimulus(4'b0001, 8'h00);
      stepTo(1 + 4 * 434 + 100);
      checkOutput("midrst_pre_tx", tx_vec[0], 1'b0);
      #2 rst = 1'b0;
      #1;
      checkOutput("midrst_tx", tx_vec[0], 1'b1);
      checkOutput("midrst_busy", busy_vec[0], 1'b0);
      checkOutput("midrst_done", done_vec[0], 1'b0);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      cur = 0;
      stepTo(2000);
      checkOutput("midrst_idle_tx", tx_vec[0], 1'b1);

      // request pending while reset releases is honoured on the first edge
      #2 rst = 1'b0;
      tx_data      = 8'h5A;
      start_vec[0] = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      start_vec = '0;
      cur = 1;
      checkOutput("rstrel_tx", tx_vec[0], 1'b0);
      checkOutput("rstrel_busy", busy_vec[0], 1'b1);
      receiveFrame(0, 434, 10, 0, line);
      checkWord("rstrel_data", {4'h0, line[8:1]}, 12'h05A);
      stepTo(4341);
      checkOutput("rstrel_done", done_vec[0], 1'b1);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
